// File: rtl/csi2_pkt_tx.sv
// csi2_pkt_tx: MIPI CSI-2 transmit packet framer for the loopback/test-pattern path.
// Emits a 4-byte header (DI, WC lo, WC hi, ECC), then for long packets the payload
// and a 2-byte CRC16 footer. Define CSI2_TX_CRC_EN to build the CRC16 footer logic;
// without it the footer is sent as 0x00 0x00 with the same state sequence and timing.
`timescale 1ns/1ps
module csi2_pkt_tx #(
    parameter int unsigned IDLE_GAP = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pkt_start_i,
    input  logic        pkt_short_i,
    input  logic [7:0]  pkt_di_i,
    input  logic [15:0] pkt_wc_i,
    output logic        busy_o,
    input  logic [7:0]  din_i,
    input  logic        din_valid_i,
    output logic        din_ready_o,
    output logic [7:0]  dout_o,
    output logic        dout_valid_o,
    input  logic        dout_ready_i,
    output logic        dout_last_o
);

    typedef enum logic [2:0] {StIdle, StHdr, StPay, StCrcLo, StCrcHi, StGap} state_e;

    localparam logic [7:0] GapCycles = IDLE_GAP[7:0];

    // CSI-2 6-bit Hamming parity over the 24 header bits; bits [7:6] are zero.
    function automatic logic [7:0] ecc_calc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11] ^ d[13] ^ d[16]
             ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        p[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[12] ^ d[14] ^ d[17]
             ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        p[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11] ^ d[12] ^ d[15] ^ d[18]
             ^ d[20] ^ d[21] ^ d[22];
        p[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13] ^ d[14] ^ d[15] ^ d[19]
             ^ d[20] ^ d[21] ^ d[23];
        p[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16] ^ d[17] ^ d[18] ^ d[19]
             ^ d[20] ^ d[22] ^ d[23];
        p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17] ^ d[18]
             ^ d[19] ^ d[21] ^ d[22] ^ d[23];
        return {2'b00, p};
    endfunction

`ifdef CSI2_TX_CRC_EN
    // Byte-parallel reflected CRC16 (x^16+x^12+x^5+1), LSB of each byte first.
    function automatic logic [15:0] crc_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [7:0] x;
        x = data ^ crc[7:0];
        x = x ^ {x[3:0], 4'b0000};
        return {x, crc[15:8]} ^ {12'h000, x[7:4]} ^ {5'b00000, x, 3'b000};
    endfunction
`endif

    state_e      state_q;
    logic [7:0]  di_q;
    logic [15:0] wc_q;
    logic        short_q;
    logic [7:0]  ecc_q;
    logic [1:0]  hdr_idx_q;
    logic [15:0] count_q;
    logic [7:0]  gap_cnt_q;
    logic [7:0]  dout_q;
    logic        dout_valid_q;
    logic        dout_last_q;

    logic        out_en;
    logic        din_fire;
    logic        pay_last;
    logic [7:0]  hdr_byte;
    logic [7:0]  foot_lo;
    logic [7:0]  foot_hi;

`ifdef CSI2_TX_CRC_EN
    logic [15:0] crc_q;
    logic [15:0] crc_d;

    assign crc_d   = crc_byte(crc_q, din_i);
    assign foot_lo = crc_q[7:0];
    assign foot_hi = crc_q[15:8];
`else
    assign foot_lo = 8'h00;
    assign foot_hi = 8'h00;
`endif

    // Output register may take a new byte when empty or being drained this cycle.
    assign out_en      = !dout_valid_q || dout_ready_i;
    assign din_ready_o = (state_q == StPay) && (count_q < wc_q) && out_en;
    assign din_fire    = din_valid_i && din_ready_o;
    // Only evaluated in PAY, where wc_q >= 1.
    assign pay_last    = (count_q == wc_q - 16'd1);

    assign busy_o       = (state_q != StIdle);
    assign dout_o       = dout_q;
    assign dout_valid_o = dout_valid_q;
    assign dout_last_o  = dout_last_q;

    // Select the header byte addressed by the header index.
    always_comb begin
        hdr_byte = di_q;
        unique case (hdr_idx_q)
            2'd0:    hdr_byte = di_q;
            2'd1:    hdr_byte = wc_q[7:0];
            2'd2:    hdr_byte = wc_q[15:8];
            default: hdr_byte = ecc_q;
        endcase
    end

    // Framer FSM together with the single output register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            di_q         <= 8'h00;
            wc_q         <= 16'h0000;
            short_q      <= 1'b0;
            ecc_q        <= 8'h00;
            hdr_idx_q    <= 2'd0;
            count_q      <= 16'h0000;
            gap_cnt_q    <= 8'h00;
            dout_q       <= 8'h00;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
`ifdef CSI2_TX_CRC_EN
            crc_q        <= 16'hFFFF;
`endif
        end else begin
            // A taken byte empties the register unless a new one is loaded below.
            if (dout_ready_i) begin
                dout_valid_q <= 1'b0;
                dout_last_q  <= 1'b0;
            end
            case (state_q)
                StIdle: begin
                    if (pkt_start_i) begin
                        di_q      <= pkt_di_i;
                        wc_q      <= pkt_wc_i;
                        short_q   <= pkt_short_i;
                        ecc_q     <= ecc_calc({pkt_wc_i, pkt_di_i});
                        count_q   <= 16'h0000;
`ifdef CSI2_TX_CRC_EN
                        crc_q     <= 16'hFFFF;
`endif
                        state_q   <= StHdr;
                        // DI goes out straight away so the header starts next cycle.
                        if (out_en) begin
                            dout_q       <= pkt_di_i;
                            dout_valid_q <= 1'b1;
                            dout_last_q  <= 1'b0;
                            hdr_idx_q    <= 2'd1;
                        end else begin
                            hdr_idx_q    <= 2'd0;
                        end
                    end
                end
                StHdr: begin
                    if (out_en) begin
                        dout_q       <= hdr_byte;
                        dout_valid_q <= 1'b1;
                        dout_last_q  <= short_q && (hdr_idx_q == 2'd3);
                        if (hdr_idx_q == 2'd3) begin
                            if (short_q) begin
                                gap_cnt_q <= 8'h00;
                                state_q   <= StGap;
                            end else if (wc_q == 16'h0000) begin
                                state_q   <= StCrcLo;
                            end else begin
                                state_q   <= StPay;
                            end
                        end else begin
                            hdr_idx_q <= hdr_idx_q + 2'd1;
                        end
                    end
                end
                StPay: begin
                    if (din_fire) begin
                        dout_q       <= din_i;
                        dout_valid_q <= 1'b1;
                        dout_last_q  <= 1'b0;
                        count_q      <= count_q + 16'd1;
`ifdef CSI2_TX_CRC_EN
                        crc_q        <= crc_d;
`endif
                        if (pay_last) begin
                            state_q <= StCrcLo;
                        end
                    end
                end
                StCrcLo: begin
                    if (out_en) begin
                        dout_q       <= foot_lo;
                        dout_valid_q <= 1'b1;
                        dout_last_q  <= 1'b0;
                        state_q      <= StCrcHi;
                    end
                end
                StCrcHi: begin
                    if (out_en) begin
                        dout_q       <= foot_hi;
                        dout_valid_q <= 1'b1;
                        dout_last_q  <= 1'b1;
                        gap_cnt_q    <= 8'h00;
                        state_q      <= StGap;
                    end
                end
                StGap: begin
                    if (gap_cnt_q == GapCycles) begin
                        state_q <= StIdle;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 8'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_csi2_pkt_tx.sv
// tb_csi2_pkt_tx: directed self-checking bench for csi2_pkt_tx (IDLE_GAP = 3).
`timescale 1ns/1ps
module tb_csi2_pkt_tx;

    localparam int unsigned Gap = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        pkt_start;
    logic        pkt_short;
    logic [7:0]  pkt_di;
    logic [15:0] pkt_wc;
    logic        busy;
    logic [7:0]  din;
    logic        din_valid;
    logic        din_ready;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        dout_last;

    int vectors     = 0;
    int miscompares = 0;
    int hold_err    = 0;

    logic [7:0] pay_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] out_q[$];
    bit         last_q[$];
    bit         prev_stall = 1'b0;
    logic [7:0] prev_dout  = 8'h00;

    // Column code of each header bit in the CSI-2 ECC generator matrix.
    localparam logic [5:0] EccCol [24] = '{
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19, 6'h1A, 6'h1C, 6'h23, 6'h25,
        6'h26, 6'h29, 6'h2A, 6'h2C, 6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

    always #5 clk = ~clk;

    csi2_pkt_tx #(.IDLE_GAP(Gap)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .pkt_start_i  (pkt_start),
        .pkt_short_i  (pkt_short),
        .pkt_di_i     (pkt_di),
        .pkt_wc_i     (pkt_wc),
        .busy_o       (busy),
        .din_i        (din),
        .din_valid_i  (din_valid),
        .din_ready_o  (din_ready),
        .dout_o       (dout),
        .dout_valid_o (dout_valid),
        .dout_ready_i (dout_ready),
        .dout_last_o  (dout_last)
    );

    // Record every output handshake and watch that stalled bytes hold still.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall && (!dout_valid || dout !== prev_dout)) hold_err <= hold_err + 1;
            if (dout_valid && dout_ready) begin
                out_q.push_back(dout);
                last_q.push_back(dout_last);
            end
            prev_stall <= dout_valid && !dout_ready;
            prev_dout  <= dout;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    function automatic logic [7:0] ecc_model(input logic [23:0] h);
        logic [5:0] s = 6'h00;
        for (int i = 0; i < 24; i++) if (h[i]) s = s ^ EccCol[i];
        return {2'b00, s};
    endfunction

    // Bit-serial reflected CRC16 over pay_q.
    function automatic logic [15:0] crc_model();
        logic [15:0] c = 16'hFFFF;
        foreach (pay_q[k]) begin
            for (int b = 0; b < 8; b++) begin
                if (c[0] ^ pay_q[k][b]) c = (c >> 1) ^ 16'h8408;
                else c = c >> 1;
            end
        end
`ifdef CSI2_TX_CRC_EN
        return c;
`else
        return 16'h0000;
`endif
    endfunction

    function automatic void build_exp(input bit sh, input logic [7:0] di, input logic [15:0] wc,
                                      input logic [7:0] flo, input logic [7:0] fhi);
        exp_q.delete();
        exp_q.push_back(di);
        exp_q.push_back(wc[7:0]);
        exp_q.push_back(wc[15:8]);
        exp_q.push_back(ecc_model({wc, di}));
        if (!sh) begin
            foreach (pay_q[k]) exp_q.push_back(pay_q[k]);
            exp_q.push_back(flo);
            exp_q.push_back(fhi);
        end
    endfunction

    task automatic wait_idle();
        int n = 0;
        pkt_start  = 1'b0;
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_wait: busy %b after %0d cycles, want 0", busy, n);
        end
        @(posedge clk);
        #1;
    endtask

    // Drive one packet; ncyc is the cycle (pkt_start cycle = 0) of the dout_last handshake.
    task automatic run_pkt(input bit sh, input logic [7:0] di, input logic [15:0] wc,
                           input bit stall, input int abort_after, input int extra_start,
                           output int ncyc, output bit done, output bit dr_seen);
        int idx = 0;
        ncyc    = 0;
        done    = 1'b0;
        dr_seen = 1'b0;
        out_q.delete();
        last_q.delete();
        pkt_short  = sh;
        pkt_di     = di;
        pkt_wc     = wc;
        pkt_start  = 1'b1;
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        @(posedge clk);
        #1;
        pkt_start = 1'b0;
        while (!done && ncyc < 5000) begin
            ncyc++;
            pkt_start  = (ncyc == extra_start);
            pkt_di     = (ncyc == extra_start) ? ~di : di;
            dout_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            din_valid  = (idx < pay_q.size()) && (stall ? 1'($urandom_range(0, 1)) : 1'b1);
            din        = (idx < pay_q.size()) ? pay_q[idx] : 8'h00;
            @(negedge clk);
            if (din_ready) dr_seen = 1'b1;
            if (din_valid && din_ready) idx++;
            if (dout_valid && dout_ready && dout_last) done = 1'b1;
            if (abort_after >= 0 && idx == abort_after) break;
            @(posedge clk);
            #1;
        end
        pkt_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %b want 0", busy); end
        vectors++;
        if (din_ready !== 1'b0) begin
            miscompares++; $display("FAIL reset din_ready: got %b want 0", din_ready);
        end
        vectors++;
        if (dout !== 8'h00) begin miscompares++; $display("FAIL reset dout: got %h want 00", dout); end
        vectors++;
        if (dout_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset dout_valid: got %b want 0", dout_valid);
        end
        vectors++;
        if (dout_last !== 1'b0) begin
            miscompares++; $display("FAIL reset dout_last: got %b want 0", dout_last);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic load_vec(input int v);
        if (v == 0) pay_q = {8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72, 8'hBB, 8'hD4,
                             8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C, 8'h81, 8'hF8, 8'h05, 8'hDF,
                             8'hFF, 8'h00, 8'h00, 8'h01};
        else pay_q = {8'hFF, 8'h00, 8'h00, 8'h00, 8'h1E, 8'hF0, 8'h1E, 8'hC7, 8'h4F, 8'h82,
                      8'h78, 8'hC5, 8'h82, 8'hE0, 8'h8C, 8'h70, 8'hD2, 8'h3C, 8'h78, 8'hE9,
                      8'hFF, 8'h00, 8'h00, 8'h01};
    endtask

    task automatic test_long_payload();
        int ncyc;
        bit done, drs;
        logic [7:0] flo [2];
        logic [7:0] fhi [2];
`ifdef CSI2_TX_CRC_EN
        flo = '{8'hF0, 8'h69};
        fhi = '{8'h00, 8'hE5};
`else
        flo = '{8'h00, 8'h00};
        fhi = '{8'h00, 8'h00};
`endif
        for (int v = 0; v < 2; v++) begin
            wait_idle();
            load_vec(v);
            build_exp(1'b0, 8'h2B, 16'd24, flo[v], fhi[v]);
            run_pkt(1'b0, 8'h2B, 16'd24, 1'b0, -1, -1, ncyc, done, drs);
            vectors++;
            if (ncyc != 30 || !done) begin
                miscompares++;
                $display("FAIL long%0d cycles: got %0d (done %b) want 30", v, ncyc, done);
            end
            vectors++;
            if (out_q.size() != exp_q.size()) begin
                miscompares++;
                $display("FAIL long%0d length: got %0d want %0d", v, out_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
                bit el = (i == exp_q.size() - 1);
                vectors++;
                if (out_q[i] !== exp_q[i] || last_q[i] !== el) begin
                    miscompares++;
                    $display("FAIL long%0d byte %0d: got %h last %b want %h last %b",
                             v, i, out_q[i], last_q[i], exp_q[i], el);
                end
            end
        end
    endtask

    task automatic test_short();
        int ncyc;
        bit done, drs;
        logic [7:0]  dis [4] = '{8'h00, 8'h2B, 8'hC5, 8'hFF};
        logic [15:0] wcs [4] = '{16'h0000, 16'h0018, 16'hA35A, 16'hFFFF};
        pay_q.delete();
        for (int v = 0; v < 4; v++) begin
            wait_idle();
            build_exp(1'b1, dis[v], wcs[v], 8'h00, 8'h00);
            run_pkt(1'b1, dis[v], wcs[v], 1'b0, -1, -1, ncyc, done, drs);
            vectors++;
            if (ncyc != 4 || !done || drs) begin
                miscompares++;
                $display("FAIL short%0d: cycles %0d done %b din_ready_seen %b want 4 1 0",
                         v, ncyc, done, drs);
            end
            vectors++;
            if (out_q.size() != 4) begin
                miscompares++; $display("FAIL short%0d length: got %0d want 4", v, out_q.size());
            end
            for (int i = 0; i < 4 && i < out_q.size(); i++) begin
                bit el = (i == 3);
                vectors++;
                if (out_q[i] !== exp_q[i] || last_q[i] !== el) begin
                    miscompares++;
                    $display("FAIL short%0d byte %0d: got %h last %b want %h last %b",
                             v, i, out_q[i], last_q[i], exp_q[i], el);
                end
            end
            if (v == 1 && out_q.size() == 4) begin
                vectors++;
                if (out_q[3] !== 8'h14) begin
                    miscompares++; $display("FAIL ecc_2b_0018: got %h want 14", out_q[3]);
                end
            end
        end
    endtask

    task automatic test_wc_zero();
        int ncyc;
        bit done, drs;
        logic [7:0] f;
`ifdef CSI2_TX_CRC_EN
        f = 8'hFF;
`else
        f = 8'h00;
`endif
        pay_q.delete();
        wait_idle();
        build_exp(1'b0, 8'h12, 16'h0000, f, f);
        run_pkt(1'b0, 8'h12, 16'h0000, 1'b0, -1, -1, ncyc, done, drs);
        vectors++;
        if (ncyc != 6 || !done || drs) begin
            miscompares++;
            $display("FAIL wc0: cycles %0d done %b din_ready_seen %b want 6 1 0", ncyc, done, drs);
        end
        vectors++;
        if (out_q.size() != 6) begin
            miscompares++; $display("FAIL wc0 length: got %0d want 6", out_q.size());
        end
        for (int i = 0; i < 6 && i < out_q.size(); i++) begin
            bit el = (i == 5);
            vectors++;
            if (out_q[i] !== exp_q[i] || last_q[i] !== el) begin
                miscompares++;
                $display("FAIL wc0 byte %0d: got %h last %b want %h last %b",
                         i, out_q[i], last_q[i], exp_q[i], el);
            end
        end
    endtask

    task automatic test_stall();
        int ncyc;
        bit done, drs;
        logic [15:0] crc;
        pay_q.delete();
        for (int i = 0; i < 300; i++) pay_q.push_back(8'($urandom_range(0, 255)));
        crc = crc_model();
        build_exp(1'b0, 8'h1E, 16'd300, crc[7:0], crc[15:8]);
        for (int pass = 0; pass < 2; pass++) begin
            wait_idle();
            run_pkt(1'b0, 8'h1E, 16'd300, pass == 1, -1, -1, ncyc, done, drs);
            vectors++;
            if (!done || (pass == 0 && ncyc != 306)) begin
                miscompares++;
                $display("FAIL stall%0d cycles: got %0d (done %b) want 306 unstalled", pass, ncyc, done);
            end
            vectors++;
            if (out_q.size() != exp_q.size()) begin
                miscompares++;
                $display("FAIL stall%0d length: got %0d want %0d", pass, out_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
                bit el = (i == exp_q.size() - 1);
                vectors++;
                if (out_q[i] !== exp_q[i] || last_q[i] !== el) begin
                    miscompares++;
                    $display("FAIL stall%0d byte %0d: got %h last %b want %h last %b",
                             pass, i, out_q[i], last_q[i], exp_q[i], el);
                end
            end
        end
        vectors++;
        if (hold_err != 0) begin
            miscompares++; $display("FAIL stall hold: %0d unstable stalled cycles, want 0", hold_err);
        end
    endtask

    task automatic test_abort();
        int ncyc, nlast;
        bit done, drs;
        logic [7:0] flo, fhi;
`ifdef CSI2_TX_CRC_EN
        flo = 8'hF0;
        fhi = 8'h00;
`else
        flo = 8'h00;
        fhi = 8'h00;
`endif
        wait_idle();
        load_vec(0);
        run_pkt(1'b0, 8'h2B, 16'd24, 1'b0, 10, -1, ncyc, done, drs);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        din_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, din_ready, dout_valid, dout_last, dout} !== 12'h000) begin
            miscompares++;
            $display("FAIL abort outputs: busy %b din_ready %b valid %b last %b dout %h want all 0",
                     busy, din_ready, dout_valid, dout_last, dout);
        end
        nlast = 0;
        foreach (last_q[k]) if (last_q[k]) nlast++;
        vectors++;
        if (done || nlast != 0) begin
            miscompares++;
            $display("FAIL abort last: done %b dout_last count %0d want 0 0", done, nlast);
        end
        wait_idle();
        build_exp(1'b0, 8'h2B, 16'd24, flo, fhi);
        run_pkt(1'b0, 8'h2B, 16'd24, 1'b0, -1, -1, ncyc, done, drs);
        vectors++;
        if (ncyc != 30 || !done || out_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL after_abort: cycles %0d done %b length %0d want 30 1 %0d",
                     ncyc, done, out_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            bit el = (i == exp_q.size() - 1);
            vectors++;
            if (out_q[i] !== exp_q[i] || last_q[i] !== el) begin
                miscompares++;
                $display("FAIL after_abort byte %0d: got %h last %b want %h last %b",
                         i, out_q[i], last_q[i], exp_q[i], el);
            end
        end
    endtask

    task automatic test_busy_start();
        int ncyc;
        bit done, drs;
        pay_q.delete();
        wait_idle();
        run_pkt(1'b1, 8'h2B, 16'h0018, 1'b0, -1, 2, ncyc, done, drs);
        vectors++;
        if (out_q.size() != 4 || !done) begin
            miscompares++;
            $display("FAIL busy_start length: got %0d done %b want 4 1", out_q.size(), done);
        end
        vectors++;
        if (out_q.size() == 4 && {out_q[0], out_q[1], out_q[2], out_q[3]} !== 32'h2B180014) begin
            miscompares++;
            $display("FAIL busy_start bytes: got %h %h %h %h want 2b 18 00 14",
                     out_q[0], out_q[1], out_q[2], out_q[3]);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vectors++;
            if (busy !== (c < 3)) begin
                miscompares++;
                $display("FAIL gap busy cycle %0d after last: got %b want %b", c + 1, busy, c < 3);
            end
        end
        repeat (8) @(negedge clk);
        vectors++;
        if (out_q.size() != 4 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ignored_start: bytes %0d busy %b want 4 0", out_q.size(), busy);
        end
    endtask

    initial begin
        rst        = 1'b1;
        pkt_start  = 1'b0;
        pkt_short  = 1'b0;
        pkt_di     = 8'h00;
        pkt_wc     = 16'h0000;
        din        = 8'h00;
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        test_reset();
        test_long_payload();
        test_short();
        test_wc_zero();
        test_stall();
        test_abort();
        test_busy_start();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/csi2_pkt_tx.md
# csi2_pkt_tx

Transmit-side MIPI CSI-2 packet framer for the loopback/test-pattern path. It takes a packet descriptor (data identifier, word count, short/long flag) and a byte stream of payload. It emits the on-wire byte sequence for the lane distributor: a 4-byte header with ECC, the payload, and a 2-byte CRC16 footer for long packets. Its output feeds the same lane path that the receive-side CRC16 checker validates.

## Interface
- IDLE_GAP, 0: minimum cycles spent in GAP after the last byte of a packet before a new pkt_start is accepted (0..255).

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- pkt_start  in  1  request a new packet; sampled only in IDLE
- pkt_short  in  1  1 = short packet (header only), 0 = long packet
- pkt_di  in  8  data identifier {VC[1:0], DT[5:0]}
- pkt_wc  in  16  long: payload byte count; short: 16-bit data field
- busy  out  1  high in any state other than IDLE
- din  in  8  payload byte
- din_valid  in  1  din holds a valid byte
- din_ready  out  1  block accepts din this cycle
- dout  out  8  output byte
- dout_valid  out  1  dout holds a valid byte
- dout_ready  in  1  downstream accepts dout this cycle
- dout_last  out  1  qualifies the final byte of a packet

## Operation
- States: IDLE, HDR, PAY, CRC_LO, CRC_HI, GAP.
- IDLE: on pkt_start=1, capture di, wc, short and latch ECC. Initialise CRC to 0xFFFF, clear byte counter, go to HDR. pkt_start outside IDLE is ignored.
- HDR: sends di, wc[7:0], wc[15:8], then ecc in that order, each on a dout handshake.
  - After the ECC byte: a short packet goes to GAP with dout_last=1 on the ECC byte.
  - A long packet with wc=0 goes to CRC_LO.
  - Otherwise it goes to PAY.
- ECC: CSI-2 6-bit Hamming parity over header bits [23:0] (di in bits 7:0); ecc[7:6]=0.
- PAY: din_ready = (PAY) && (count < wc) && (!dout_valid || dout_ready).
  - On din_valid && din_ready: load dout with din, increment count, and update CRC with din.
  - After the byte with count == wc has been handed off, go to CRC_LO.
- CRC: CSI-2 polynomial x^16+x^12+x^5+1, LSB-first (reflected), init 0xFFFF, no final XOR.
- CRC_LO sends crc[7:0]. CRC_HI sends crc[15:8] with dout_last=1, then goes to GAP.
- GAP: counts IDLE_GAP cycles, then goes to IDLE. With IDLE_GAP=0 it goes straight to IDLE on the next cycle.
- dout, dout_valid and dout_last come from a single output register. It loads when !dout_valid || dout_ready, and dout_valid clears when the last byte is taken with no new byte loaded.
- Word count arithmetic is 16-bit unsigned. A wc of 65535 is legal, so the counter is 16 bits and never wraps inside a packet.

## Timing
- Reset values: busy=0, din_ready=0, dout=0x00, dout_valid=0, dout_last=0; state=IDLE; CRC=0xFFFF.
- rst asserted mid-packet returns the block to IDLE on the next edge. The partial packet is discarded with no dout_last, and the output register is cleared.
- First header byte is valid 1 cycle after the pkt_start cycle.
- Payload latency is 1 cycle from a din handshake to dout_valid.
- Throughput is 1 byte/cycle with dout_ready held high, so a long packet with no stalls takes wc+6 cycles from pkt_start to the last handshake.
- dout is stable while dout_valid=1 && dout_ready=0.
- din_valid low in PAY inserts bubbles; dout_valid drops and no CRC update occurs.
- din_ready is 0 in every state except PAY.

## Configuration
- CSI2_TX_CRC_EN defined: the footer carries the computed CRC16.
- CSI2_TX_CRC_EN undefined: no CRC logic is built. The footer is 0x00, 0x00 (the CSI-2 "CRC not computed" value) with identical state sequence and timing.

## Test plan
- Long packet, DI=0x2B, WC=24, payload FF 00 00 02 B9 DC F3 72 BB D4 B8 5A C8 75 C2 7C 81 F8 05 DF FF 00 00 01 -> dout = 2B 18 00 ECC, 24 payload bytes, F0 00; dout_last on 00; 30 bytes in 30 cycles.
- Payload FF 00 00 00 1E F0 1E C7 4F 82 78 C5 82 E0 8C 70 D2 3C 78 E9 FF 00 00 01 -> footer 69 E5. With CSI2_TX_CRC_EN undefined -> footer 00 00.
- Short packet, DI=0x00, WC=0x0000 -> dout 00 00 00 00, dout_last on 4th byte, din_ready never high. ECC for DI=0x2B / WC=0x0018 / others matches the table-driven ECC model.
- Long packet with WC=0 -> header then FF FF footer; din_ready never asserts.
- Random dout_ready (50%) and din_valid (50%) stalls, WC=300 -> byte stream identical to the no-stall run; dout held stable during stalls.
- rst pulsed in PAY after 10 bytes, then pkt_start, plus pkt_start during busy and IDLE_GAP=3 -> outputs at reset values the cycle after rst, no dout_last for the aborted packet. Packet after reset is correct, start while busy is ignored, and busy stays high 3 cycles after dout_last.
